// File: rtl/button_event_arbiter_if.sv
// Button/event bundle between the push-button front end and the mode/edit/timer logic.
// The arbiter takes the slave view; whoever drives the buttons takes the master view.
interface button_event_arbiter_if;
  logic [4:0] btn;
  logic       evt_valid;
  logic [2:0] evt_id;
  logic       busy;
  logic       hold_active;

  modport master (
    output btn,
    input  evt_valid, evt_id, busy, hold_active
  );

  modport slave (
    input  btn,
    output evt_valid, evt_id, busy, hold_active
  );
endinterface

// File: rtl/button_event_arbiter.sv
// Synchronises five push-buttons and arbitrates them through one shared hold counter,
// emitting one qualified event per long-press. Define AUTO_REPEAT_EN for INC auto-repeat.
module button_event_arbiter #(
  parameter int HOLD_CYCLES   = 15_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int SYNC_STAGES   = 2
) (
  input logic                    clk,
  input logic                    reset,
  button_event_arbiter_if.slave  bus
);

  localparam int NUM_BTN = 5;
  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [2:0]       INC_IDX     = 3'd3;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
`ifdef AUTO_REPEAT_EN
    ,
    REPEAT  = 2'd3
`endif
  } state_t;

  // ---------------------------------------------------------------------------
  // Button synchroniser
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] sync_q [SYNC_STAGES];
  logic [NUM_BTN-1:0] s;

  // NOTE: this array is a chain of real flops, not a RAM, so it is cleared on
  // reset; otherwise a stale press could be seen right after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.btn;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Lowest index wins: clear > mode > shift > inc > start_stop.
  function automatic logic [2:0] first_set(input logic [NUM_BTN-1:0] v);
    first_set = 3'd0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (v[i]) first_set = 3'(i);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Arbitration FSM
  // ---------------------------------------------------------------------------
  state_t           state,  state_next;
  logic [CNT_W-1:0] cnt,    cnt_next;
  logic [2:0]       grant,  grant_next;
  logic             fire;
  logic             evt_valid_q;
  logic [2:0]       evt_id_q;

  // NOTE: sequential state uses non-blocking assignments so every flop sees the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      grant       <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      grant       <= grant_next;
      evt_valid_q <= fire;
      if (fire) evt_id_q <= grant + 3'd1;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    grant_next = grant;
    fire       = 1'b0;

    unique case (state)
      IDLE: begin
        if (s != '0) begin
          grant_next = first_set(s);
          state_next = HOLD;
        end
      end

      HOLD: begin
        // A release on the very cycle the count completes is still an abort.
        if (!s[grant]) begin
          state_next = IDLE;
        end else if (cnt == HOLD_LAST) begin
          fire = 1'b1;
`ifdef AUTO_REPEAT_EN
          state_next = (grant == INC_IDX) ? REPEAT : RELEASE;
`else
          state_next = RELEASE;
`endif
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      RELEASE: begin
        if (s == '0) state_next = IDLE;
      end

`ifdef AUTO_REPEAT_EN
      REPEAT: begin
        if (!s[INC_IDX]) begin
          state_next = RELEASE;
        end else if (cnt == REPEAT_LAST) begin
          fire     = 1'b1;
          cnt_next = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
`endif

      default: state_next = IDLE;
    endcase

    // The counter restarts from zero on every state entry.
    if (state_next != state) cnt_next = '0;
  end

  always_comb begin
    bus.evt_valid   = evt_valid_q;
    bus.evt_id      = evt_id_q;
    bus.busy        = (state != IDLE);
    bus.hold_active = (state == HOLD);
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with an expected-event scoreboard.
// Expected event cycles are derived from the press times; reacts to AUTO_REPEAT_EN.
module tb_button_event_arbiter;

  localparam int HOLD   = 4;
  localparam int REPEAT = 3;
  localparam int SYNC   = 2;

  typedef struct {
    int         cyc;
    logic [2:0] id;
  } exp_evt_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   c;
  exp_evt_t exp_q[$];

  button_event_arbiter_if bus ();

  button_event_arbiter #(
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REPEAT),
    .SYNC_STAGES   (SYNC)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, sample 1 time unit later, and retire any event.
  task automatic step();
    exp_evt_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.evt_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL unexpected_evt: observed id %0d at cycle %0d, expected no event",
               bus.evt_id, cyc);
      end else begin
        e = exp_q.pop_front();
        check("evt_cycle", 32'(cyc), 32'(e.cyc));
        check("evt_id", 32'(bus.evt_id), 32'(e.id));
      end
    end
  endtask

  task automatic to_cycle(input int t);
    while (cyc < t) step();
  endtask

  task automatic expect_evt(input int at, input logic [2:0] id);
    exp_evt_t e;
    e.cyc = at;
    e.id  = id;
    exp_q.push_back(e);
  endtask

  // A press driven just after edge c is first seen by the FSM at edge c+SYNC+1 (E0).
  function automatic int e0_of(input int c0);
    return c0 + SYNC + 1;
  endfunction

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.btn  = '0;

    // Reset state
    repeat (3) step();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_hold_active", 32'(bus.hold_active), 32'd0);
    check("rst_evt_valid", 32'(bus.evt_valid), 32'd0);
    check("rst_evt_id", 32'(bus.evt_id), 32'd0);
    reset = 1'b0;
    to_cycle(cyc + 3);

    // INC held for 3 synced cycles only: abort, no event, evt_id stays 0
    c = cyc;
    bus.btn = 5'b01000;
    to_cycle(e0_of(c));
    check("abort_hold_active", 32'(bus.hold_active), 32'd1);
    bus.btn = 5'b00000;
    to_cycle(e0_of(c) + 4);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_evt_id", 32'(bus.evt_id), 32'd0);
    to_cycle(cyc + 4);

    // MODE held 10 cycles: one event HOLD edges after E0, busy window
    c = cyc;
    bus.btn = 5'b00010;
    expect_evt(e0_of(c) + HOLD, 3'd2);
    to_cycle(e0_of(c) - 1);
    check("mode_busy_pre_e0", 32'(bus.busy), 32'd0);
    to_cycle(e0_of(c));
    check("mode_busy_at_e0", 32'(bus.busy), 32'd1);
    to_cycle(c + 10);
    bus.btn = 5'b00000;
    to_cycle(c + 10 + SYNC);
    check("mode_busy_release", 32'(bus.busy), 32'd1);
    to_cycle(c + 10 + SYNC + 1);
    check("mode_busy_idle", 32'(bus.busy), 32'd0);
    check("mode_evt_id_hold", 32'(bus.evt_id), 32'd2);
    to_cycle(cyc + 3);

    // Simultaneous 11010: MODE wins, nothing after release
    c = cyc;
    bus.btn = 5'b11010;
    expect_evt(e0_of(c) + HOLD, 3'd2);
    to_cycle(c + 10);
    bus.btn = 5'b00000;
    to_cycle(c + 20);
    check("simul_busy", 32'(bus.busy), 32'd0);
    check("simul_evt_id", 32'(bus.evt_id), 32'd2);

    // START_STOP held, CLEAR added during HOLD: no preemption, RELEASE waits for all
    c = cyc;
    bus.btn = 5'b10000;
    expect_evt(e0_of(c) + HOLD, 3'd5);
    to_cycle(e0_of(c) + 1);
    bus.btn = 5'b10001;
    to_cycle(e0_of(c) + 3);
    check("nopreempt_hold_active", 32'(bus.hold_active), 32'd1);
    to_cycle(c + 10);
    bus.btn = 5'b00001;
    to_cycle(c + 14);
    check("release_wait_busy", 32'(bus.busy), 32'd1);
    check("release_wait_hold", 32'(bus.hold_active), 32'd0);
    bus.btn = 5'b00000;
    to_cycle(c + 14 + SYNC);
    check("release_last_busy", 32'(bus.busy), 32'd1);
    to_cycle(c + 14 + SYNC + 1);
    check("release_done_busy", 32'(bus.busy), 32'd0);
    to_cycle(cyc + 3);

    // CLEAR+MODE, CLEAR dropped so the abort lands on the final hold cycle:
    // abort wins, MODE is re-granted from IDLE with a fresh count
    c = cyc;
    bus.btn = 5'b00011;
    to_cycle(c + 4);
    bus.btn = 5'b00010;
    expect_evt(c + 8 + HOLD, 3'd2);
    to_cycle(c + 7);
    check("regrant_idle_busy", 32'(bus.busy), 32'd0);
    to_cycle(c + 8);
    check("regrant_hold_active", 32'(bus.hold_active), 32'd1);
    to_cycle(c + 14);
    bus.btn = 5'b00000;
    to_cycle(c + 20);

    // Reset pulsed mid-HOLD (cnt=2) with MODE still held
    c = cyc;
    bus.btn = 5'b00010;
    to_cycle(e0_of(c) + 2);
    reset = 1'b1;
    to_cycle(e0_of(c) + 3);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_hold_active", 32'(bus.hold_active), 32'd0);
    check("midrst_evt_valid", 32'(bus.evt_valid), 32'd0);
    check("midrst_evt_id", 32'(bus.evt_id), 32'd0);
    reset = 1'b0;
    // First edge with reset low is c+7; the held button looks like a fresh press there.
    expect_evt(c + 7 + SYNC + HOLD, 3'd2);
    to_cycle(c + 7 + SYNC);
    check("postrst_hold_active", 32'(bus.hold_active), 32'd1);
    to_cycle(c + 16);
    bus.btn = 5'b00000;
    to_cycle(c + 22);

    // INC held 12 cycles: repeat pulses only when the feature is compiled in
    c = cyc;
    bus.btn = 5'b01000;
    expect_evt(e0_of(c) + HOLD, 3'd4);
`ifdef AUTO_REPEAT_EN
    expect_evt(e0_of(c) + HOLD + REPEAT, 3'd4);
    expect_evt(e0_of(c) + HOLD + 2 * REPEAT, 3'd4);
`endif
    to_cycle(c + 12);
    bus.btn = 5'b00000;
    to_cycle(c + 22);
    check("inc_busy", 32'(bus.busy), 32'd0);
    check("inc_evt_id", 32'(bus.evt_id), 32'd4);

    check("events_outstanding", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
Front-end controller for the clock/edit/timer mode logic. It synchronises the five push-buttons and arbitrates them through one shared hold-time counter. It emits a single qualified, one-cycle event per long-press, so downstream mode/edit/timer sequencing no longer carries per-button hold counters. Fixed-priority, non-preemptive: one button is serviced at a time, and all buttons must be released before the next grant.

Parameters:
HOLD_CYCLES, 15_000_000, clk cycles a granted button must stay high before its event fires (min 2)
REPEAT_CYCLES, 5_000_000, auto-repeat period for INC when the optional feature is compiled in (min 2)
SYNC_STAGES, 2, flip-flop stages in each button synchroniser (min 2)

Ports:
clk  input  1  system clock
reset  input  1  system reset, synchronous, active-high
btn  input  5  raw buttons; [0]=clear, [1]=mode, [2]=edit_shift, [3]=inc, [4]=start_stop
evt_valid  output  1  one-cycle pulse, event qualified
evt_id  output  3  code of last event: 1=clear, 2=mode, 3=shift, 4=inc, 5=start_stop; 0 after reset
busy  output  1  high whenever FSM not in IDLE
hold_active  output  1  high while in HOLD (drives press-feedback LED)

Behaviour:
- Reset (synchronous): sync flops=0, FSM=IDLE, hold counter=0, grant=0, evt_valid=0, evt_id=0, busy=0, hold_active=0.
- Synchroniser: SYNC_STAGES flops per bit; all logic below uses the synced vector `s`.
- Priority: lowest index wins (clear > mode > shift > inc > start_stop).
- Counter: hold counter ceil(log2(max(HOLD_CYCLES,REPEAT_CYCLES))) bits wide, never wraps; it is cleared on every state entry.
- FSM states IDLE, HOLD, RELEASE (+REPEAT when AUTO_REPEAT_EN):
  - IDLE: if s!=0, latch grant=index of highest-priority set bit, cnt<=0, go HOLD (edge E0). Else stay.
  - HOLD: if s[grant]==0, go IDLE with no event (abort). Else if cnt==HOLD_CYCLES-1: register evt_valid=1, evt_id=grant+1, go RELEASE. Else cnt<=cnt+1.
  - RELEASE: stay while s!=0; go IDLE on first cycle s==0.
- Latency: evt_valid is high exactly HOLD_CYCLES edges after E0 (HOLD_CYCLES cycles of continuous high on s[grant]). Add SYNC_STAGES for latency from the raw pin.
- evt_valid is high for exactly 1 cycle. evt_id holds its value until the next event.
- Simultaneous presses in IDLE: highest priority granted; others are ignored, not queued.
- Higher-priority button asserted during HOLD: no preemption; the granted hold continues. After the event, RELEASE blocks until all buttons are low.
- Granted button released and re-pressed within one cycle: counts as an abort; the new press restarts from IDLE.
- Lower-priority button held when the granted button aborts: IDLE re-grants it next cycle with cnt=0.
- Reset asserted mid-HOLD or mid-RELEASE: immediate return to reset state, no event. A button held through reset deassertion is treated as a fresh press after SYNC_STAGES cycles.
- busy = (state!=IDLE); hold_active = (state==HOLD); both are registered-state decodes.

Optional Feature:
AUTO_REPEAT_EN
- Defined: when the INC event (grant=3) fires, the FSM goes to REPEAT instead of RELEASE, with cnt<=0.
  - In REPEAT, while s[3]==1: cnt increments; at cnt==REPEAT_CYCLES-1 it emits evt_valid=1, evt_id=4, cnt<=0.
  - s[3]==0 → go RELEASE.
  - Other buttons are ignored in REPEAT.
- Undefined: INC behaves like every other button (single event, then RELEASE). The REPEAT state and REPEAT_CYCLES logic are absent.

Test Plan:
(All scenarios use HOLD_CYCLES=4, REPEAT_CYCLES=3, SYNC_STAGES=2.)
- btn=5'b00010 held 10 cycles → exactly one evt_valid pulse 4 edges after E0, evt_id=2; busy high from E0 until 1 cycle after s returns to 0.
- btn=5'b01000 held 3 synced cycles then released → no evt_valid; FSM back in IDLE; evt_id stays 0.
- btn=5'b11010 asserted together and held → one pulse with evt_id=2 (mode); after release of all buttons, no further events.
- btn[4] held; at cycle 2 of HOLD assert btn[0] → event evt_id=5 (no preemption); RELEASE persists until both are released.
- btn[1] held; reset pulsed 1 cycle at HOLD cnt=2 → no event, all outputs 0; with btn still held, event fires at 2+4 edges after reset deasserts, evt_id=2.
- AUTO_REPEAT_EN defined, btn[3] held 12 cycles → pulses at +4, +7, +10 edges after E0, each with evt_id=4; undefined → a single pulse at +4 only.
